// File: rtl/regsr_cfg_pkg.sv
// Shared types and constants for the RegSRx8 configuration sequencer.
package regsr_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    FIN
  } seq_state_t;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam int unsigned REG_STRIDE    = 4;
  localparam logic [3:0]  WSTRB_ALL     = 4'hF;
  localparam logic [2:0]  AXI_PROT_NONE = 3'b000;

  // Width of an index counter over n registers (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regsr_axil_wr_hs.sv
// Tracks completion of the independent AW and W handshakes of one AXI4-Lite
// write. "complete" is high in the cycle in which the second of the two
// handshakes happens (or both together).
module regsr_axil_wr_hs (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic awvalid,
  input  logic awready,
  input  logic wvalid,
  input  logic wready,
  output logic complete
);

  logic aw_seen;
  logic w_seen;
  logic aw_hs;
  logic w_hs;

  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  assign complete = (aw_seen | aw_hs) & (w_seen | w_hs);

  // Remember each handshake until both have happened, then rearm.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (reset || clear || complete) begin
      aw_seen <= 1'b0;
      w_seen  <= 1'b0;
    end else begin
      if (aw_hs) aw_seen <= 1'b1;
      if (w_hs)  w_seen  <= 1'b1;
    end
  end

endmodule

// File: rtl/regsr_cfg_sequencer.sv
// AXI4-Lite master that writes a captured NUM_REGS-word image to consecutive
// registers of the RegSRx8 bank and reports busy/done/error/err_index.
// Build option: define REGSR_READBACK_EN to add the read-back/compare phase;
// without it the read channels are held idle and only bresp can flag errors.
module regsr_cfg_sequencer
  import regsr_cfg_pkg::*;
#(
  parameter int  NUM_REGS = 4,
  parameter int  DATA_W   = 32,
  parameter int  ADDR_W   = 4,
  localparam int IDX_W    = idx_width(NUM_REGS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [NUM_REGS*DATA_W-1:0]   cfg_data,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [IDX_W-1:0]             err_index,
  output logic [ADDR_W-1:0]            m_axi_awaddr,
  output logic [2:0]                   m_axi_awprot,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [DATA_W-1:0]            m_axi_wdata,
  output logic [DATA_W/8-1:0]          m_axi_wstrb,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  input  logic [1:0]                   m_axi_bresp,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  output logic [ADDR_W-1:0]            m_axi_araddr,
  output logic [2:0]                   m_axi_arprot,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  input  logic [DATA_W-1:0]            m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  seq_state_t                  state;
  logic [IDX_W-1:0]            idx;
  logic [IDX_W-1:0]            idx_inc;
  logic [ADDR_W-1:0]           base_q;
  logic [NUM_REGS*DATA_W-1:0]  shadow;
  logic                        accept;
  logic                        aw_hs;
  logic                        w_hs;
  logic                        wr_complete;

  assign accept  = (state == IDLE) && start;
  assign idx_inc = idx + 1'b1;
  assign aw_hs   = m_axi_awvalid & m_axi_awready;
  assign w_hs    = m_axi_wvalid & m_axi_wready;

  assign m_axi_awprot = AXI_PROT_NONE;
  assign m_axi_arprot = AXI_PROT_NONE;
  assign m_axi_wstrb  = WSTRB_ALL;

  // Byte address of register i; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_at(input logic [ADDR_W-1:0] base,
                                                input logic [IDX_W-1:0]  i);
    return base + ADDR_W'(32'(i) * REG_STRIDE);
  endfunction

  // Shadow image word i.
  function automatic logic [DATA_W-1:0] word_at(input logic [IDX_W-1:0] i);
    return shadow[32'(i) * DATA_W +: DATA_W];
  endfunction

  regsr_axil_wr_hs u_wr_hs (
    .clock    (clock),
    .reset    (reset),
    .clear    (state != WR_ADDR),
    .awvalid  (m_axi_awvalid),
    .awready  (m_axi_awready),
    .wvalid   (m_axi_wvalid),
    .wready   (m_axi_wready),
    .complete (wr_complete)
  );

  // Capture the base address and config image when a sequence is accepted.
  always_ff @(posedge clock) begin
    // NOTE: pure data storage is left unreset; it is always loaded before it is read.
    if (accept) begin
      base_q <= base_addr;
      shadow <= cfg_data;
    end
  end

  // Sequencer FSM with registered AXI and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_index     <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
`ifdef REGSR_READBACK_EN
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            idx           <= '0;
            busy          <= 1'b1;
            error         <= 1'b0;
            err_index     <= '0;
            m_axi_awaddr  <= base_addr;
            m_axi_wdata   <= cfg_data[DATA_W-1:0];
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= WR_ADDR;
          end
        end

        WR_ADDR: begin
          if (aw_hs) m_axi_awvalid <= 1'b0;
          if (w_hs)  m_axi_wvalid  <= 1'b0;
          if (wr_complete) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != AXI_RESP_OKAY) begin
              error     <= 1'b1;
              err_index <= idx;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
            end else if (idx == LAST_IDX) begin
`ifdef REGSR_READBACK_EN
              idx           <= '0;
              m_axi_araddr  <= base_q;
              m_axi_arvalid <= 1'b1;
              state         <= RD_ADDR;
`else
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
`endif
            end else begin
              idx           <= idx_inc;
              m_axi_awaddr  <= addr_at(base_q, idx_inc);
              m_axi_wdata   <= word_at(idx_inc);
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_ADDR;
            end
          end
        end

`ifdef REGSR_READBACK_EN
        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rdata != word_at(idx))) begin
              error     <= 1'b1;
              err_index <= idx;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
            end else if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              idx           <= idx_inc;
              m_axi_araddr  <= addr_at(base_q, idx_inc);
              m_axi_arvalid <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
`endif

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef REGSR_READBACK_EN
  assign m_axi_araddr  = '0;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;

  logic unused_rd_inputs;
  assign unused_rd_inputs = ^{m_axi_arready, m_axi_rvalid, m_axi_rresp, m_axi_rdata};
`endif

endmodule

// File: tb/tb_regsr_cfg_sequencer.sv
// Self-checking bench for regsr_cfg_sequencer: a bench-side AXI4-Lite slave
// with a write/read scoreboard, plus status and latency checks.
module tb_regsr_cfg_sequencer;
  import regsr_cfg_pkg::*;

  localparam int NUM_REGS    = 4;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 4;
  localparam int IDX_W       = 2;
  localparam int CYCLE_LIMIT = 200;
`ifdef REGSR_READBACK_EN
  localparam int RB_READS = NUM_REGS;
`else
  localparam int RB_READS = 0;
`endif
  localparam int FULL_CYCLES = 2 * NUM_REGS + 2 * RB_READS + 1;

  logic                        clock;
  logic                        reset;
  logic                        start;
  logic [ADDR_W-1:0]           base_addr;
  logic [NUM_REGS*DATA_W-1:0]  cfg_data;
  logic                        busy, done, error;
  logic [IDX_W-1:0]            err_index;
  logic [ADDR_W-1:0]           awaddr, araddr;
  logic [2:0]                  awprot, arprot;
  logic                        awvalid, awready, wvalid, wready;
  logic [DATA_W-1:0]           wdata, rdata;
  logic [3:0]                  wstrb;
  logic [1:0]                  bresp, rresp;
  logic                        bvalid, bready, arvalid, arready, rvalid, rready;

  regsr_cfg_sequencer #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .cfg_data(cfg_data),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  wr_exp_t           exp_wr[$];
  logic [ADDR_W-1:0] exp_rd[$];

  // Slave knobs and state
  logic [DATA_W-1:0] mem [NUM_REGS];
  int                aw_delay     = 0;
  int                aw_wait      = 0;
  int                wr_count     = 0;
  int                err_wr_num   = -1;
  int                w_first_seen = 0;
  logic              b_hold       = 1'b0;
  logic              corrupt_en   = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  logic              got_aw, got_w;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic              aw_v_q, aw_r_q, w_v_q, w_r_q, b_v_q, b_r_q, ar_v_q, ar_r_q, r_v_q, r_r_q;
  logic [ADDR_W-1:0] awaddr_q, araddr_q;
  logic [DATA_W-1:0] wdata_q;

  // AXI4-Lite slave: acts on the falling edge, looking back at the handshakes
  // that the preceding rising edge completed.
  initial begin : slave
    wr_exp_t e;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clock);
      if (reset) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        got_aw = 1'b0; got_w = 1'b0; aw_wait = 0;
        aw_v_q = 1'b0; aw_r_q = 1'b0; w_v_q = 1'b0; w_r_q = 1'b0; b_v_q = 1'b0; b_r_q = 1'b0;
        ar_v_q = 1'b0; ar_r_q = 1'b0; r_v_q = 1'b0; r_r_q = 1'b0;
        awaddr_q = '0; araddr_q = '0; wdata_q = '0;
      end else begin
        // A raised valid must stay up until its handshake.
        if (aw_v_q && !aw_r_q) check("awvalid_stable", awvalid, 1);
        if (w_v_q && !w_r_q)   check("wvalid_stable", wvalid, 1);
        if (ar_v_q && !ar_r_q) check("arvalid_stable", arvalid, 1);

        if (aw_v_q && aw_r_q) begin got_aw = 1'b1; cap_addr = awaddr_q; end
        if (w_v_q && w_r_q)   begin got_w = 1'b1;  cap_data = wdata_q;  end
        if (b_v_q && b_r_q)   bvalid = 1'b0;
        if (r_v_q && r_r_q)   rvalid = 1'b0;

        if (got_w && !got_aw) begin
          w_first_seen++;
          check("wvalid_dropped_after_hs", wvalid, 0);
          check("awvalid_held_before_hs", awvalid, 1);
        end

        if (got_aw && got_w) begin
          check("wr_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            check("wr_addr", cap_addr, e.addr);
            check("wr_data", cap_data, e.data);
          end
          check("wstrb", wstrb, 4'hF);
          check("awprot", awprot, 3'b000);
          mem[cap_addr[3:2]] = cap_data;
          if (!b_hold) begin
            bvalid = 1'b1;
            bresp  = (wr_count == err_wr_num) ? 2'b10 : 2'b00;
          end
          wr_count++;
          got_aw = 1'b0;
          got_w  = 1'b0;
        end

        if (ar_v_q && ar_r_q) begin
          check("rd_expected", exp_rd.size() != 0, 1);
          if (exp_rd.size() != 0) check("rd_addr", araddr_q, exp_rd.pop_front());
          check("arprot", arprot, 3'b000);
          rvalid = 1'b1;
          rresp  = 2'b00;
          rdata  = (corrupt_en && araddr_q == corrupt_addr) ? '0 : mem[araddr_q[3:2]];
        end

        if (awvalid && !got_aw) begin
          if (aw_wait >= aw_delay) awready = 1'b1;
          else begin awready = 1'b0; aw_wait++; end
        end else begin
          awready = 1'b0;
          aw_wait = 0;
        end
        wready  = wvalid && !got_w;
        arready = arvalid;

        aw_v_q = awvalid; aw_r_q = awready; awaddr_q = awaddr;
        w_v_q  = wvalid;  w_r_q  = wready;  wdata_q  = wdata;
        b_v_q  = bvalid;  b_r_q  = bready;
        ar_v_q = arvalid; ar_r_q = arready; araddr_q = araddr;
        r_v_q  = rvalid;  r_r_q  = rready;
      end
    end
  end

  task automatic push_expected(input logic [ADDR_W-1:0] base, input logic [NUM_REGS*DATA_W-1:0] cfg,
                               input int n_wr, input int n_rd);
    wr_exp_t e;
    for (int i = 0; i < n_wr; i++) begin
      e.addr = base + ADDR_W'(4 * i);
      e.data = cfg[i*DATA_W +: DATA_W];
      exp_wr.push_back(e);
    end
    for (int i = 0; i < n_rd; i++) exp_rd.push_back(base + ADDR_W'(4 * i));
  endtask

  task automatic check_outputs_idle(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_error"}, error, 0);
    check({name, "_err_index"}, err_index, 0);
    check({name, "_awvalid"}, awvalid, 0);
    check({name, "_wvalid"}, wvalid, 0);
    check({name, "_bready"}, bready, 0);
    check({name, "_arvalid"}, arvalid, 0);
    check({name, "_rready"}, rready, 0);
    check({name, "_awaddr"}, awaddr, 0);
    check({name, "_araddr"}, araddr, 0);
    check({name, "_wdata"}, wdata, 0);
  endtask

  // One full sequence: push expectations, pulse start, wait for done.
  task automatic run_seq(input string name, input logic [ADDR_W-1:0] base,
                         input logic [NUM_REGS*DATA_W-1:0] cfg, input int n_wr, input int n_rd,
                         input logic exp_err, input logic [IDX_W-1:0] exp_idx,
                         input int exp_cycles, input int extra_at);
    int cnt;
    push_expected(base, cfg, n_wr, n_rd);
    wr_count = 0;
    @(negedge clock);
    start = 1'b1; base_addr = base; cfg_data = cfg;
    @(posedge clock);
    cnt = 1;
    @(negedge clock);
    start = 1'b0; base_addr = ~base; cfg_data = ~cfg;
    check({name, "_busy_after_start"}, busy, 1);
    while (!done && cnt < CYCLE_LIMIT) begin
      check({name, "_busy_running"}, busy, 1);
      start = (cnt == extra_at);
      @(posedge clock);
      cnt++;
      @(negedge clock);
    end
    start = 1'b0;
    check({name, "_done_seen"}, done, 1);
    check({name, "_busy_at_done"}, busy, 0);
    check({name, "_error"}, error, exp_err);
    if (exp_err) check({name, "_err_index"}, err_index, exp_idx);
    if (exp_cycles > 0) check({name, "_latency"}, cnt, exp_cycles);
    @(negedge clock);
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_error_held"}, error, exp_err);
    check({name, "_writes_left"}, exp_wr.size(), 0);
    check({name, "_reads_left"}, exp_rd.size(), 0);
    exp_wr.delete();
    exp_rd.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [NUM_REGS*DATA_W-1:0] cfg;
    int cnt;
    reset = 1'b1; start = 1'b0; base_addr = '0; cfg_data = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_outputs_idle("reset");
    reset = 1'b0;
    @(negedge clock);

    // 1: basic image, zero-wait slave
    run_seq("t1", 4'h0, {32'd4, 32'd3, 32'd2, 32'd1}, NUM_REGS, RB_READS, 1'b0, '0, FULL_CYCLES, 0);

    // 2: AW accepted 3 cycles late, W immediately
    aw_delay = 3;
    w_first_seen = 0;
    run_seq("t2", 4'h0, {32'hDEAD_0004, 32'hBEEF_0003, 32'hCAFE_0002, 32'hF00D_0001},
            NUM_REGS, RB_READS, 1'b0, '0, 0, 0);
    check("t2_w_before_aw_seen", w_first_seen > 0, 1);
    aw_delay = 0;

    // 3: SLVERR on the third write aborts the sequence
    err_wr_num = 2;
    run_seq("t3", 4'h0, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
            3, 0, 1'b1, 2'd2, 0, 0);
    err_wr_num = -1;

    // 4: slave returns 0 at 0x4 on read-back
    corrupt_en = 1'b1;
    corrupt_addr = 4'h4;
    run_seq("t4", 4'h0, {32'hA5A5_0004, 32'h5A5A_0003, 32'h1234_0002, 32'h8765_0001},
            NUM_REGS, (RB_READS > 0) ? 2 : 0, (RB_READS > 0), 2'd1,
            (RB_READS > 0) ? 0 : FULL_CYCLES, 0);
    corrupt_en = 1'b0;

    // 5: reset while waiting for a write response
    b_hold = 1'b1;
    cfg = {32'h0000_0044, 32'h0000_0033, 32'h0000_0022, 32'h0000_0011};
    push_expected(4'h0, cfg, NUM_REGS, 0);
    @(negedge clock);
    start = 1'b1; base_addr = 4'h0; cfg_data = cfg;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    cnt = 0;
    while (!bready && cnt < CYCLE_LIMIT) begin
      @(negedge clock);
      cnt++;
    end
    check("t5_reached_wr_resp", bready, 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_outputs_idle("t5_reset");
    reset = 1'b0;
    b_hold = 1'b0;
    exp_wr.delete();
    exp_rd.delete();
    @(negedge clock);
    run_seq("t5_restart", 4'h0, {32'h0000_0444, 32'h0000_0333, 32'h0000_0222, 32'h0000_0111},
            NUM_REGS, RB_READS, 1'b0, '0, FULL_CYCLES, 0);

    // 6: base 0xC wraps; a start pulse while busy is ignored
    run_seq("t6", 4'hC, {32'h6666_0004, 32'h6666_0003, 32'h6666_0002, 32'h6666_0001},
            NUM_REGS, RB_READS, 1'b0, '0, FULL_CYCLES, 3);

    repeat (3) @(negedge clock);
    check("final_idle_busy", busy, 0);
    check("final_no_pending_writes", exp_wr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
